// File: rtl/fpu_round.sv
// Three-stage IEEE-754 binary64 rounding: pre-normalise, round-increment, post-normalise.
// Output fields feed fpu_exceptions directly; no special-value handling happens here.
module fpu_round (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        in_valid,
  input  logic [1:0]  round_mode,
  input  logic        sign_term,
  input  logic [11:0] exponent_term,
  input  logic [55:0] mantissa_term,
  output logic [63:0] round_out,
  output logic [11:0] exponent_final,
  output logic [1:0]  round_bits,
  output logic        out_valid
);

  // Valid semantics: in_valid is sampled on every edge with enable=1; the operand's
  // result appears with out_valid=1 after the third enabled edge. There is no ready;
  // enable=0 freezes every stage (including out_valid) and rst discards all flights.

  // S1: pre-normalise
  logic        s1_valid;
  logic        s1_sign;
  logic [1:0]  s1_mode;
  logic [11:0] s1_exp;
  logic [54:0] s1_norm;
  logic [54:0] norm_d;
  logic [11:0] exp1_d;

  always_comb begin
    norm_d = mantissa_term[54:0];
    exp1_d = exponent_term;
    if (mantissa_term[55]) begin
      // shift right one place, folding the dropped bit into sticky
      norm_d = {mantissa_term[55:2], mantissa_term[1] | mantissa_term[0]};
      exp1_d = exponent_term + 12'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_mode  <= 2'b00;
      s1_exp   <= 12'd0;
      s1_norm  <= 55'd0;
    end else if (enable) begin
      s1_valid <= in_valid;
      s1_sign  <= sign_term;
      s1_mode  <= round_mode;
      s1_exp   <= exp1_d;
      s1_norm  <= norm_d;
    end
  end

  // S2: round decision and increment
  logic        s2_valid;
  logic        s2_sign;
  logic [11:0] s2_exp;
  logic [53:0] s2_sum;
  logic [1:0]  s2_rb;
  logic        inc;
  logic        lsb_b;
  logic        guard_b;
  logic        sticky_b;
  logic [53:0] sum_d;

  always_comb begin
    lsb_b    = s1_norm[2];
    guard_b  = s1_norm[1];
    sticky_b = s1_norm[0];
    inc      = 1'b0;
    case (s1_mode)
      2'b00:   inc = guard_b & (sticky_b | lsb_b);
      2'b01:   inc = 1'b0;
      2'b10:   inc = (guard_b | sticky_b) & ~s1_sign;
      default: inc = (guard_b | sticky_b) & s1_sign;
    endcase
    sum_d = {1'b0, s1_norm[54:2]} + {53'd0, inc};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_exp   <= 12'd0;
      s2_sum   <= 54'd0;
      s2_rb    <= 2'b00;
    end else if (enable) begin
      s2_valid <= s1_valid;
      s2_sign  <= s1_sign;
      s2_exp   <= s1_exp;
      s2_sum   <= sum_d;
      s2_rb    <= s1_norm[1:0];
    end
  end

  // S3: post-normalise and pack
  logic [51:0] frac_d;
  logic [11:0] expf_d;

  always_comb begin
    frac_d = s2_sum[51:0];
    expf_d = s2_exp;
    if (s2_sum[53]) begin
      frac_d = s2_sum[52:1];
      expf_d = s2_exp + 12'd1;
    end else if ((s2_exp == 12'd0) && s2_sum[52]) begin
      // subnormal rounded up into the smallest normal
      expf_d = 12'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid      <= 1'b0;
      round_out      <= 64'd0;
      exponent_final <= 12'd0;
      round_bits     <= 2'b00;
    end else if (enable) begin
      out_valid      <= s2_valid;
      round_out      <= {s2_sign, expf_d[10:0], frac_d};
      exponent_final <= expf_d;
      round_bits     <= s2_rb;
    end
  end

endmodule

// File: doc/fpu_round.md
# fpu_round

Pipelined rounding stage of the double-precision FPU. It takes the sign, the extended exponent and the unrounded 56-bit mantissa term from the add/sub/mul/div datapaths. It applies the IEEE-754 rounding mode and produces the packed 64-bit result, the 12-bit final exponent and the two discarded rounding bits. `fpu_exceptions` consumes these outputs directly as `in_except`, `exponent_in` and `mantissa_in`.

## Interface
- No parameters; widths fixed for binary64.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- enable  in  1  pipeline advance; when low every register holds.
- in_valid  in  1  qualifies the input operands this cycle.
- round_mode  in  2  00 nearest-even, 01 toward zero, 10 toward +inf, 11 toward -inf.
- sign_term  in  1  result sign.
- exponent_term  in  12  biased exponent, pre-rounding.
- mantissa_term  in  56  [55] carry, [54] hidden, [53:2] fraction, [1] guard, [0] sticky.
- round_out  out  64  {sign, exponent_final[10:0], fraction[51:0]}.
- exponent_final  out  12  post-rounding exponent; feeds overflow detection downstream.
- round_bits  out  2  {guard, sticky} after pre-normalisation; downstream uses it for the inexact flag.
- out_valid  out  1  qualifies the outputs.

## Operation
- Three register stages: S1, S2, S3. Each stage loads only when enable=1.
- **S1, pre-normalise.**
  - If mantissa_term[55]=1: norm[54:0] = {mantissa_term[55:2], mantissa_term[1]|mantissa_term[0]} and exp1 = exponent_term+1.
  - Otherwise: norm = mantissa_term[54:0] and exp1 = exponent_term.
  - Also register sign, round_mode and in_valid.
- **S2, round decision and add.** Let lsb=norm[2], g=norm[1], s=norm[0].
  - inc per mode: 00: g&(s|lsb); 01: 0; 10: (g|s)&!sign; 11: (g|s)&sign.
  - sum[53:0] = {1'b0, norm[54:2]} + inc.
  - Register sum, exp1, sign, norm[1:0] and valid.
- **S3, post-normalise.**
  - If sum[53]=1: fraction = sum[52:1] (all zero) and exponent_final = exp+1.
  - Else if exp==0 and sum[52]=1 (subnormal rounded up to normal): fraction = sum[51:0] and exponent_final = 1.
  - Else: fraction = sum[51:0] and exponent_final = exp.
- Exponent arithmetic is unsigned modulo 2^12. No saturation here; exponent_final > 2046 is handled by `fpu_exceptions`.
- round_out[62:52] = exponent_final[10:0]. round_bits = registered norm[1:0].
- No special-value detection (NaN, Inf, zero). Those operands pass through unchanged; `fpu_exceptions` overrides the result.

## Timing
- Latency: exactly 3 enabled clock edges from in_valid sampled to out_valid asserted.
- Throughput: one operand per enabled cycle. No backpressure beyond enable.
- enable=0 freezes all stages, including out_valid. Outputs stay stable and no data is lost or duplicated.
- Reset:
  - All pipeline registers clear.
  - round_out=0, exponent_final=0, round_bits=0, out_valid=0 on the first edge with rst=1.
  - rst has priority over enable.
  - Reset mid-flight discards all in-flight operands; no out_valid pulse follows.
- When enable=1 and in_valid=0, a bubble propagates. Data registers still load; out_valid=0 marks the bubble.
- round_mode is sampled per operand in S1. Changing it does not affect operands already past S1.

## Test plan
- **1.0, no rounding.** sign=0, exp=1023, mantissa=56'h40_0000_0000_0000, mode 00 -> after 3 edges round_out=64'h3FF0_0000_0000_0000, exponent_final=1023, round_bits=00.
- **Ties-to-even.**
  - mantissa=56'h40_0000_0000_0002 -> round_out=3FF0_0000_0000_0000, round_bits=10.
  - mantissa=56'h40_0000_0000_0006 -> round_out=3FF0_0000_0000_0002, round_bits=10.
- **Carry-out of rounding.** exp=1023, mantissa=56'h7F_FFFF_FFFF_FFFF.
  - Mode 10, sign 0 -> round_out=4000_0000_0000_0000, exponent_final=1024.
  - Mode 01 -> 3FFF_FFFF_FFFF_FFFF, exponent_final=1023.
  - Mode 11, sign 1 -> C000_0000_0000_0000.
- **Input carry and overflow.**
  - mantissa=56'h80_0000_0000_0000, exp=1023 -> round_out=4000_0000_0000_0000, exponent_final=1024.
  - exp=2046, mantissa=56'h7F_FFFF_FFFF_FFFF, mode 00 -> exponent_final=2047, round_out=7FF0_0000_0000_0000.
- **Stall.** Back-to-back operands A, B, C with enable deasserted for 2 cycles mid-stream -> outputs held unchanged during the stall; A, B, C each emerge exactly once, in order, with out_valid high.
- **Reset mid-operation.** Two operands in flight, rst pulsed 1 cycle -> all outputs 0 the next cycle; out_valid stays 0 until a new in_valid is followed by 3 enabled edges.
